// File: rtl/sh4_wb_arb_if.sv
// sh4_wb_arb_if: bundle of the write-back arbiter's request, accept,
// register-file write and scoreboard signals.
//
// Handshake rule for ex0/ex1/mem: a request is accepted on a rising edge
// where both valid and ready are high. A requester may hold valid while
// ready is low. ready never depends combinationally on the same-channel
// valid.
//
// Modports:
//   slave  - the arbiter (takes requests, drives readies, rf_* and busy)
//   master - the requester/observer side (drives requests)
interface sh4_wb_arb_if;
    logic        ex0_valid;
    logic        ex0_ready;
    logic [3:0]  ex0_dst;
    logic        ex0_bank;
    logic [31:0] ex0_data;

    logic        ex1_valid;
    logic        ex1_ready;
    logic [3:0]  ex1_dst;
    logic        ex1_bank;
    logic [31:0] ex1_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_dst;
    logic        mem_bank;
    logic [31:0] mem_data;

    logic        rf_wen0;
    logic [3:0]  rf_wdst0;
    logic        rf_wbank0;
    logic [31:0] rf_wdata0;

    logic        rf_wen1;
    logic [3:0]  rf_wdst1;
    logic        rf_wbank1;
    logic [31:0] rf_wdata1;

    logic [23:0] busy;

    modport slave (
        input  ex0_valid, ex0_dst, ex0_bank, ex0_data,
        input  ex1_valid, ex1_dst, ex1_bank, ex1_data,
        input  mem_valid, mem_dst, mem_bank, mem_data,
        output ex0_ready, ex1_ready, mem_ready,
        output rf_wen0, rf_wdst0, rf_wbank0, rf_wdata0,
        output rf_wen1, rf_wdst1, rf_wbank1, rf_wdata1,
        output busy
    );

    modport master (
        output ex0_valid, ex0_dst, ex0_bank, ex0_data,
        output ex1_valid, ex1_dst, ex1_bank, ex1_data,
        output mem_valid, mem_dst, mem_bank, mem_data,
        input  ex0_ready, ex1_ready, mem_ready,
        input  rf_wen0, rf_wdst0, rf_wbank0, rf_wdata0,
        input  rf_wen1, rf_wdst1, rf_wbank1, rf_wdata1,
        input  busy
    );
endinterface

// File: rtl/sh4_wb_arb.sv
// sh4_wb_arb: two-port register-file write-back arbiter.
//   ex0 writes always go to port 0, ex1 writes to port 1 (ex1 is younger, so
//   it wins an equal-destination race by landing on the higher port).
//   Load returns are buffered in an in-order FIFO and drained one per cycle
//   into whichever port is free. A starvation counter forces a drain on
//   port 1 (holding off ex1) if the FIFO head waits STARVE_LIMIT cycles.
//   busy[] flags every physical register with a load still in flight.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - sh4_wb_arb_if.slave: ex0/ex1/mem requests, rf write ports, busy
module sh4_wb_arb #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    sh4_wb_arb_if.slave   bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Banked registers R0-R7 (bank 1) live at physical 16..23.
    function automatic logic [4:0] phys_idx(input logic [3:0] dst, input logic bank);
        if (!dst[3] && bank) phys_idx = {2'b10, dst[2:0]};
        else                 phys_idx = {1'b0, dst};
    endfunction

    logic [3:0]    f_dst_q  [FIFO_DEPTH];
    logic          f_bank_q [FIFO_DEPTH];
    logic [31:0]   f_data_q [FIFO_DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [SW-1:0] starve_q, starve_d;

    logic          wen0_q, mem0_q, wbank0_q;
    logic [3:0]    wdst0_q;
    logic [31:0]   wdata0_q;
    logic          wen1_q, mem1_q, wbank1_q;
    logic [3:0]    wdst1_q;
    logic [31:0]   wdata1_q;

    logic          nonempty, forced;
    logic          ex0_acc, ex1_acc, mem_acc;
    logic          drain0, drain1, drain;
    logic [23:0]   busy_v;

    assign nonempty = (count_q != '0);
    assign forced   = nonempty && (starve_q == SW'(STARVE_LIMIT));

    // mem_ready uses the registered count only: a full FIFO stays closed
    // even in a cycle where the head drains.
    assign bus.ex0_ready = !rst;
    assign bus.ex1_ready = !rst && !forced;
    assign bus.mem_ready = !rst && (count_q < CW'(FIFO_DEPTH));

    assign ex0_acc = bus.ex0_valid && bus.ex0_ready;
    assign ex1_acc = bus.ex1_valid && bus.ex1_ready;
    assign mem_acc = bus.mem_valid && bus.mem_ready;

    always_comb begin
        drain0 = 1'b0;
        drain1 = 1'b0;
        if (nonempty && !rst) begin
            if (forced)              drain1 = 1'b1;
            else if (!bus.ex0_valid) drain0 = 1'b1;
            else if (!ex1_acc)       drain1 = 1'b1;
        end
        drain   = drain0 || drain1;
        count_d = count_q + CW'(mem_acc) - CW'(drain);

        starve_d = starve_q;
        if (!nonempty || drain)                starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (mem_acc) begin
            f_dst_q[wr_ptr_q]  <= bus.mem_dst;
            f_bank_q[wr_ptr_q] <= bus.mem_bank;
            f_data_q[wr_ptr_q] <= bus.mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            starve_q <= '0;
            wen0_q   <= 1'b0;
            mem0_q   <= 1'b0;
            wdst0_q  <= '0;
            wbank0_q <= 1'b0;
            wdata0_q <= '0;
            wen1_q   <= 1'b0;
            mem1_q   <= 1'b0;
            wdst1_q  <= '0;
            wbank1_q <= 1'b0;
            wdata1_q <= '0;
        end else begin
            count_q  <= count_d;
            starve_q <= starve_d;
            if (mem_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (drain)   rd_ptr_q <= rd_ptr_q + PW'(1);

            wen0_q <= ex0_acc || drain0;
            mem0_q <= drain0;
            if (ex0_acc) begin
                wdst0_q  <= bus.ex0_dst;
                wbank0_q <= bus.ex0_bank;
                wdata0_q <= bus.ex0_data;
            end else if (drain0) begin
                wdst0_q  <= f_dst_q[rd_ptr_q];
                wbank0_q <= f_bank_q[rd_ptr_q];
                wdata0_q <= f_data_q[rd_ptr_q];
            end

            wen1_q <= ex1_acc || drain1;
            mem1_q <= drain1;
            if (ex1_acc) begin
                wdst1_q  <= bus.ex1_dst;
                wbank1_q <= bus.ex1_bank;
                wdata1_q <= bus.ex1_data;
            end else if (drain1) begin
                wdst1_q  <= f_dst_q[rd_ptr_q];
                wbank1_q <= f_bank_q[rd_ptr_q];
                wdata1_q <= f_data_q[rd_ptr_q];
            end
        end
    end

    // A load stays busy while buffered and through its rf_wen cycle.
    always_comb begin
        busy_v = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            logic [PW-1:0] offs;
            offs = PW'(k) - rd_ptr_q;
            if ({1'b0, offs} < count_q) busy_v[phys_idx(f_dst_q[k], f_bank_q[k])] = 1'b1;
        end
        if (wen0_q && mem0_q) busy_v[phys_idx(wdst0_q, wbank0_q)] = 1'b1;
        if (wen1_q && mem1_q) busy_v[phys_idx(wdst1_q, wbank1_q)] = 1'b1;
    end

    assign bus.busy      = rst ? 24'd0 : busy_v;
    assign bus.rf_wen0   = wen0_q;
    assign bus.rf_wdst0  = wdst0_q;
    assign bus.rf_wbank0 = wbank0_q;
    assign bus.rf_wdata0 = wdata0_q;
    assign bus.rf_wen1   = wen1_q;
    assign bus.rf_wdst1  = wdst1_q;
    assign bus.rf_wbank1 = wbank1_q;
    assign bus.rf_wdata1 = wdata1_q;
endmodule

// File: tb/tb_sh4_wb_arb.sv
module tb_sh4_wb_arb;
  typedef logic [36:0] wr_t;  // {dst, bank, data}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sh4_wb_arb_if bus();

  sh4_wb_arb #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t exp0_q[$];
  wr_t exp1_q[$];
  wr_t e0, e1;
  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex0_valid = 1'b0; bus.ex0_dst = '0; bus.ex0_bank = 1'b0; bus.ex0_data = '0;
    bus.ex1_valid = 1'b0; bus.ex1_dst = '0; bus.ex1_bank = 1'b0; bus.ex1_data = '0;
    bus.mem_valid = 1'b0; bus.mem_dst = '0; bus.mem_bank = 1'b0; bus.mem_data = '0;
  endtask

  task automatic drive_ex0(input logic [3:0] d, input logic b, input logic [31:0] v);
    bus.ex0_valid = 1'b1; bus.ex0_dst = d; bus.ex0_bank = b; bus.ex0_data = v;
  endtask

  task automatic drive_ex1(input logic [3:0] d, input logic b, input logic [31:0] v);
    bus.ex1_valid = 1'b1; bus.ex1_dst = d; bus.ex1_bank = b; bus.ex1_data = v;
  endtask

  task automatic drive_mem(input logic [3:0] d, input logic b, input logic [31:0] v);
    bus.mem_valid = 1'b1; bus.mem_dst = d; bus.mem_bank = b; bus.mem_data = v;
  endtask

  // Monitor: every rf write pulse is matched against the per-port queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rf_wen0) begin
        if (exp0_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL port0_write: got unexpected 0x%0h expected none",
                   {bus.rf_wdst0, bus.rf_wbank0, bus.rf_wdata0});
        end else begin
          e0 = exp0_q.pop_front();
          chk("port0_write", {27'd0, bus.rf_wdst0, bus.rf_wbank0, bus.rf_wdata0}, {27'd0, e0});
        end
      end
      if (bus.rf_wen1) begin
        if (exp1_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL port1_write: got unexpected 0x%0h expected none",
                   {bus.rf_wdst1, bus.rf_wbank1, bus.rf_wdata1});
        end else begin
          e1 = exp1_q.pop_front();
          chk("port1_write", {27'd0, bus.rf_wdst1, bus.rf_wbank1, bus.rf_wdata1}, {27'd0, e1});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_ex0_ready", bus.ex0_ready, 0);
    chk("rst_ex1_ready", bus.ex1_ready, 0);
    chk("rst_mem_ready", bus.mem_ready, 0);
    chk("rst_wen", {bus.rf_wen0, bus.rf_wen1}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wdata0", bus.rf_wdata0, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {bus.ex0_ready, bus.ex1_ready, bus.mem_ready}, 3'b111);
    mon_en = 1'b1;

    // ---------------- single load ----------------
    drive_mem(4'd3, 1'b0, 32'h11);
    exp0_q.push_back({4'd3, 1'b0, 32'h11});
    tick();
    idle();
    chk("single_busy3_buffered", bus.busy[3], 1);
    chk("single_no_early_wen", bus.rf_wen0, 0);
    tick();
    chk("single_wen0", bus.rf_wen0, 1);
    chk("single_busy3_writing", bus.busy[3], 1);
    tick();
    chk("single_busy3_clear", bus.busy, 0);
    tick();

    // ---------------- dual ex, same dst ----------------
    drive_ex0(4'd1, 1'b0, 32'hA);
    drive_ex1(4'd1, 1'b0, 32'hB);
    exp0_q.push_back({4'd1, 1'b0, 32'hA});
    exp1_q.push_back({4'd1, 1'b0, 32'hB});
    tick();
    idle();
    chk("dual_both_wen", {bus.rf_wen0, bus.rf_wen1}, 2'b11);
    tick();

    // ---------------- bank mapping ----------------
    drive_mem(4'd5, 1'b1, 32'h55);
    tick();
    idle();
    // ex0 busy holds port 0, so the buffered load drains on port 1.
    drive_ex0(4'd5, 1'b0, 32'h66);
    exp0_q.push_back({4'd5, 1'b0, 32'h66});
    exp1_q.push_back({4'd5, 1'b1, 32'h55});
    chk("bank_busy21", bus.busy[21], 1);
    chk("bank_busy5", bus.busy[5], 0);
    tick();
    idle();
    chk("bank_busy_writing", bus.busy, 24'h200000);
    tick();
    chk("bank_busy_clear", bus.busy, 0);
    tick();

    // ---------------- full FIFO and forced drain ----------------
    for (int k = 0; k < 10; k++) begin
      idle();
      drive_ex0(4'd8, 1'b0, 32'h300 + k);
      drive_ex1(4'd9, 1'b0, 32'h200 + k);
      exp0_q.push_back({4'd8, 1'b0, 32'h300 + k});
      if (k < 4) drive_mem(4'(k), 1'b0, 32'h100 + k);
      if (k < 9) exp1_q.push_back({4'd9, 1'b0, 32'h200 + k});
      else       exp1_q.push_back({4'd0, 1'b0, 32'h100});
      if (k == 3) chk("full_mem_ready_c3", bus.mem_ready, 1);
      if (k == 4) chk("full_mem_ready_c4", bus.mem_ready, 0);
      if (k == 8) chk("full_ex1_ready_c8", bus.ex1_ready, 1);
      if (k == 9) begin
        chk("full_ex1_ready_forced", bus.ex1_ready, 0);
        chk("full_busy", bus.busy, 24'h00000F);
      end
      tick();
    end
    idle();
    chk("full_mem_ready_after_drain", bus.mem_ready, 1);
    exp0_q.push_back({4'd1, 1'b0, 32'h101});
    exp0_q.push_back({4'd2, 1'b0, 32'h102});
    exp0_q.push_back({4'd3, 1'b0, 32'h103});
    repeat (5) tick();
    chk("full_busy_clear", bus.busy, 0);

    // ---------------- mid-operation reset ----------------
    for (int k = 0; k < 3; k++) begin
      idle();
      drive_mem(4'(12 + k), 1'b0, 32'h700 + k);
      drive_ex0(4'd10, 1'b0, 32'h400 + k);
      drive_ex1(4'd11, 1'b0, 32'h500 + k);
      exp0_q.push_back({4'd10, 1'b0, 32'h400 + k});
      exp1_q.push_back({4'd11, 1'b0, 32'h500 + k});
      tick();
    end
    idle();
    chk("midrst_busy_before", bus.busy, 24'h007000);
    rst = 1'b1;
    #1;
    chk("midrst_ready_in_rst", {bus.ex0_ready, bus.ex1_ready, bus.mem_ready}, 0);
    chk("midrst_busy_in_rst", bus.busy, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy_after", bus.busy, 0);
    chk("midrst_mem_ready", bus.mem_ready, 1);
    chk("midrst_no_wen", {bus.rf_wen0, bus.rf_wen1}, 0);
    repeat (6) tick();
    chk("midrst_busy_idle", bus.busy, 0);

    chk("exp0_drained", exp0_q.size(), 0);
    chk("exp1_drained", exp1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sh4_wb_arb.md
SH4_WB_ARB -- requirements
Module: sh4_wb_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning load-return buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning cycles a buffered load may wait before port 1 is forcibly reserved for it.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex0_valid / ex0_ready  in / out  1 / 1  pipe-0 write request and accept.
- ex0_dst / ex0_bank / ex0_data  in  4 / 1 / 32  pipe-0 destination, bank, data.
- ex1_valid / ex1_ready  in / out  1 / 1  pipe-1 write request and accept.
- ex1_dst / ex1_bank / ex1_data  in  4 / 1 / 32  pipe-1 destination, bank, data.
- mem_valid / mem_ready  in / out  1 / 1  load-return request and accept.
- mem_dst / mem_bank / mem_data  in  4 / 1 / 32  load-return destination, bank, data.
- rf_wen0 / rf_wdst0 / rf_wbank0 / rf_wdata0  out  1 / 4 / 1 / 32  register-file write port 0.
- rf_wen1 / rf_wdst1 / rf_wbank1 / rf_wdata1  out  1 / 4 / 1 / 32  register-file write port 1.
- busy  out  24  pending-load scoreboard, one bit per physical register.

Function
REQ-004 SHALL map a (dst, bank) pair to a physical index: dst[3]==0 and bank==1 gives 16+dst[2:0]; otherwise dst.
REQ-005 SHALL accept a request on a cycle when valid and ready are both high at the rising edge.
REQ-006 SHALL drive ex0_ready=1 whenever rst is low.
REQ-007 SHALL drive ex1_ready=1 whenever rst is low, except during forced drain (REQ-013).
REQ-008 SHALL drive mem_ready = (FIFO count < FIFO_DEPTH), using the registered count, with no same-cycle dequeue bypass.
REQ-009 SHALL register all rf_* outputs, so a write accepted or drained in cycle N appears on the ports for exactly cycle N+1.
REQ-010 SHALL route accepted ex0 writes to port 0 and accepted ex1 writes to port 1, so that ex1 (younger) wins on an equal destination.
REQ-011 SHALL hold accepted mem writes in an in-order FIFO; a load never bypasses the FIFO, so minimum accept-to-rf_wen latency is 2 cycles.
REQ-012 SHALL drain at most one FIFO head per cycle, using the first free port: port 0 if ex0_valid is low, else port 1 if ex1 is not accepted that cycle.
REQ-013 SHALL keep a starvation counter that:
- increments each cycle the FIFO is non-empty and the head does not drain, saturating at STARVE_LIMIT;
- clears on a drain or when the FIFO is empty.
REQ-014 SHALL enter forced drain while the counter equals STARVE_LIMIT: ex1_ready=0 and the head drains on port 1 that cycle.
REQ-015 SHALL allow enqueue and dequeue in the same cycle when not full; count is unchanged and pointers wrap modulo FIFO_DEPTH.
REQ-016 SHALL set busy[i] when any valid FIFO entry, or a registered port write that originated from mem, targets physical index i; busy drops the cycle after that rf_wen pulse.
REQ-017 SHALL require upstream never to present an ex write whose physical index is busy; the block does no WAW checking.

Reset
REQ-018 SHALL, while rst is high, force:
- all ready outputs to 0;
- rf_wen0, rf_wen1 and busy to 0;
- FIFO count, read/write pointers and starvation counter to 0;
- rf_wdst*, rf_wbank* and rf_wdata* to 0.
REQ-019 SHALL discard all buffered loads on reset asserted mid-operation; no rf_wen may pulse in the cycle after rst is sampled high.

Verification
REQ-020 Single load: mem write R3 bank0 data 0x11 into an idle block -> busy[3]=1 from the next cycle; rf_wen0=1, rf_wdst0=3, data 0x11 two cycles after accept; busy[3]=0 the cycle after that.
REQ-021 Dual ex: ex0 R1=0xA and ex1 R1=0xB in the same cycle -> next cycle rf_wen0 and rf_wen1 both 1, wdst 1, wdata0=0xA, wdata1=0xB.
REQ-022 Bank mapping: mem R5 bank1, then ex0 R5 bank0 -> busy[21]=1 and busy[5]=0; port writes carry wbank 1 and 0 respectively.
REQ-023 Full FIFO: 4 back-to-back loads while ex0 and ex1 are valid every cycle -> mem_ready=0 after the 4th accept; forced drain starts after 8 stalled cycles with ex1_ready=0 and the head on port 1.
REQ-024 Mid-op reset: rst pulsed with 3 loads buffered -> busy=0 and no rf_wen after reset; mem_ready=1 in the first cycle after rst goes low.
